ex_div_ctrl: RTL and testbench

EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

---
 rtl/ex_div_ctrl_pkg.sv | 19 +
 rtl/ex_div_ctrl_div_step.sv | 24 ++
 rtl/ex_div_ctrl.sv | 100 ++++++++++
 tb/tb_ex_div_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: func3 encodings, FSM states and op decode for the EX-stage divider
package ex_div_ctrl_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    function automatic logic is_signed_op(input logic [2:0] f);
        return (f == F3_DIV) | (f == F3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f);
        return !((f == F3_DIV) | (f == F3_DIVU));
    endfunction

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// ex_div_ctrl_div_step: one restoring shift-subtract step (partial remainder, trial subtract, quotient bit)
module ex_div_ctrl_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            borrow;
    logic            unused_top;

    always_comb begin
        shifted = {rem, bit_in};
        {borrow, unused_top, diff} = {1'b0, shifted} - {2'b0, divisor};
        q_bit = ~borrow;
        rem_next = q_bit ? diff : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle restoring divider for DIV/DIVU/REM/REMU with pipeline stall control.
// Define DIV_EARLY_OUT_EN to finish trivial cases (divide by zero, overflow, |op1|<|op2|) in one cycle.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_rem, neg_q, neg_r;
    logic [XLEN-1:0] dq, dvs, rem;
    logic [XLEN-1:0] rem_nx, q_fin, fin, abs1, abs2, early_res;
    logic            q_bit, sgn_in, early;

    ex_div_ctrl_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .bit_in   (dq[XLEN-1]),
        .divisor  (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_comb begin
        sgn_in = is_signed_op(i_func3);
        abs1 = (sgn_in & i_op1[XLEN-1]) ? -i_op1 : i_op1;
        abs2 = (sgn_in & i_op2[XLEN-1]) ? -i_op2 : i_op2;
        q_fin = {dq[XLEN-2:0], q_bit};
        fin = is_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -q_fin : q_fin);
`ifdef DIV_EARLY_OUT_EN
        early = (i_op2 == '0) | (abs1 < abs2) | (sgn_in & (i_op1 == MIN_NEG) & (i_op2 == '1));
        early_res = is_rem_op(i_func3) ? ((i_op2 == '0 || abs1 < abs2) ? i_op1 : '0)
                                       : (i_op2 == '0 ? '1 : (abs1 < abs2 ? '0 : i_op1));
`else
        early = 1'b0;
        early_res = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
            cnt <= '0;
            o_result <= '0;
            dq <= '0;
            dvs <= '0;
            rem <= '0;
            is_rem <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    is_rem <= is_rem_op(i_func3);
                    // a zero divisor keeps the all-ones quotient regardless of signs
                    neg_q <= sgn_in & (i_op1[XLEN-1] ^ i_op2[XLEN-1]) & (i_op2 != '0);
                    neg_r <= sgn_in & i_op1[XLEN-1];
                    dq <= abs1;
                    dvs <= abs2;
                    rem <= '0;
                    cnt <= CW'(XLEN-1);
                    state <= early ? S_DONE : S_ITER;
                    if (early) o_result <= early_res;
                end
                S_ITER: begin
                    dq <= q_fin;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_DONE;
                        o_result <= fin;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = state != S_IDLE;
    assign o_stall = ~rst_n & (((state == S_IDLE) & i_start & ~i_flush) | (state == S_ITER));
    assign o_valid = ~rst_n & ~i_flush & (state == S_DONE);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed and random stimulus against a behavioural divider model kept in the bench.
`timescale 1ns/1ps
module tb_ex_div_ctrl;

    localparam int XLEN = 32;
    localparam int LAT = XLEN + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
    localparam int EL = 1;
`else
    localparam int EL = LAT;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            i_start = 1'b0;
    logic            i_flush = 1'b0;
    logic [2:0]      i_func3 = 3'b100;
    logic [XLEN-1:0] i_op1 = '0;
    logic [XLEN-1:0] i_op2 = '0;
    logic            o_busy, o_stall, o_valid;
    logic [XLEN-1:0] o_result;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit              m_act = 1'b0;
    int              m_left = 0;
    logic [XLEN-1:0] m_res = '0;
    logic [XLEN-1:0] m_last = '0;

    ex_div_ctrl #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_func3  (i_func3),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_stall  (o_stall),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] ref_div(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bit sgn = (f == 3'b100) || (f == 3'b110);
        bit want_rem = (f == 3'b110) || (f == 3'b111);
        longint sa = sgn ? longint'($signed(a)) : longint'(a);
        longint sb = sgn ? longint'($signed(b)) : longint'(b);
        if (b == '0) return want_rem ? a : '1;
        return want_rem ? XLEN'(sa % sb) : XLEN'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        bit sgn = (f == 3'b100) || (f == 3'b110);
        longint ma = sgn ? longint'($signed(a)) : longint'(a);
        longint mb = sgn ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == '0 || ma < mb || (sgn && a == MIN_NEG && b == '1)) return 1;
`endif
        return LAT;
    endfunction

    function automatic logic [XLEN-1:0] rand_op();
        case ($urandom % 8)
            0: return '0;
            1: return '1;
            2: return MIN_NEG;
            3: return XLEN'($urandom % 16);
            4: return XLEN'($urandom % 1000);
            5: return -XLEN'($urandom % 1000);
            default: return XLEN'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare DUT to the model mid-cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", o_busy, m_act);
            chk("stall", o_stall, !rst_n && ((!m_act && i_start && !i_flush) || (m_act && m_left > 0)));
            chk("valid", o_valid, !rst_n && !i_flush && m_act && m_left == 0);
            chk("result", o_result, m_last);
        end
        if (rst_n) begin
            m_act <= 1'b0;
            m_last <= '0;
        end else if (i_flush) begin
            m_act <= 1'b0;
        end else if (m_act) begin
            m_act <= m_left != 0;
            m_left <= m_left - 1;
            if (m_left == 1) m_last <= m_res;
        end else if (i_start) begin
            m_act <= 1'b1;
            m_res <= ref_div(i_func3, i_op1, i_op2);
            m_left <= ref_lat(i_func3, i_op1, i_op2) - 1;
            if (ref_lat(i_func3, i_op1, i_op2) == 1) m_last <= ref_div(i_func3, i_op1, i_op2);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_lat);
        int n;
        i_start = 1'b1;
        i_func3 = f;
        i_op1 = a;
        i_op2 = b;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 1;
        while (!o_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, n, exp_lat);
        chk(name, o_result, exp_res);
        @(posedge clk); #1;
    endtask

    initial begin
        chk("model DIVU 100/7", ref_div(3'b101, 100, 7), 14);
        chk("model REM -7/2", ref_div(3'b110, -32'sd7, 2), 32'hFFFF_FFFF);
        chk("model DIV ovf", ref_div(3'b100, MIN_NEG, '1), MIN_NEG);
        chk("model REM 5/0", ref_div(3'b110, 5, 0), 5);

        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset result", o_result, 0);
        chk("reset busy", o_busy, 0);
        i_start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        i_start = 1'b0;
        @(posedge clk); #1;

        run_op("DIVU 100/7", 3'b101, 100, 7, 14, LAT);
        run_op("REMU 100/7", 3'b111, 100, 7, 2, LAT);
        run_op("DIV -7/2", 3'b100, -32'sd7, 2, 32'hFFFF_FFFD, LAT);
        run_op("REM -7/2", 3'b110, -32'sd7, 2, 32'hFFFF_FFFF, LAT);
        run_op("DIV 5/0", 3'b100, 5, 0, 32'hFFFF_FFFF, EL);
        run_op("REM 5/0", 3'b110, 5, 0, 5, EL);
        run_op("DIV ovf", 3'b100, MIN_NEG, '1, MIN_NEG, EL);
        run_op("REM ovf", 3'b110, MIN_NEG, '1, 0, EL);
        run_op("DIVU 3/9", 3'b101, 3, 9, 0, EL);
        run_op("REMU 3/9", 3'b111, 3, 9, 3, EL);
        run_op("DIV -100/-7", 3'b100, -32'sd100, -32'sd7, 14, LAT);
        run_op("REM -100/-7", 3'b110, -32'sd100, -32'sd7, 32'hFFFF_FFFE, LAT);
        run_op("DIVU -1/1", 3'b101, '1, 1, '1, LAT);

        // flush in cycle 10, restart in cycle 12, result expected in cycle 45
        i_start = 1'b1;
        i_func3 = 3'b101;
        i_op1 = 1000;
        i_op2 = 3;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush idle", o_busy, 0);
        @(posedge clk); #1;
        run_op("DIVU after flush", 3'b101, 1000, 3, 333, LAT);

        // reset in cycle 20 of a DIV, with a start held during reset
        i_start = 1'b1;
        i_func3 = 3'b100;
        i_op1 = -32'sd50;
        i_op2 = 7;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        i_start = 1'b0;
        chk("reset mid busy", o_busy, 0);
        chk("reset mid result", o_result, 0);
        run_op("DIV after reset", 3'b100, -32'sd50, 7, 32'hFFFF_FFF9, LAT);

        repeat (4000) begin
            i_start = ($urandom % 3) == 0;
            i_func3 = 3'(4 + $urandom % 4);
            i_op1 = rand_op();
            i_op2 = rand_op();
            i_flush = ($urandom % 60) == 0;
            rst_n = ($urandom % 400) == 0;
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        i_flush = 1'b0;
        rst_n = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
